// File: rtl/prng_seq.sv
// Multi-channel Fibonacci LFSR random source with seed snapshot, replay and
// entropy-mixed reseed followed by a warm-up burst.
module prng_seq #(
    parameter int             W         = 16,
    parameter int             CH        = 2,
    parameter int             LA        = 4,
    parameter logic [W-1:0]   TAPS      = W'(16'hB400),
    parameter logic [W-1:0]   SEED_BASE = W'(16'h0001),
    parameter int             WARMUP    = 16,
    parameter int             POS_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               rerun,
    input  logic               randomize,
    output logic [CH-1:0]      random,
    output logic [CH*LA-1:0]   randLA,
    output logic [POS_W-1:0]   pos,
    output logic               busy
);

    typedef enum logic {ST_IDLE, ST_WARMUP} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       s_q [CH];
    logic [W-1:0]       s_d [CH];
    logic [W-1:0]       z_q [CH];
    logic [W-1:0]       z_d [CH];
    logic [W-1:0]       e_q;
    logic [W-1:0]       mix;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic               busy_q, busy_d;

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return {s[W-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
        logic [W-1:0] o;
        o = '0;
        for (int i = 0; i < W; i++) begin
            o[(i + r) % W] = v[i];
        end
        return o;
    endfunction

    function automatic logic [W-1:0] seed_of(input int c);
        return SEED_BASE + W'(c);
    endfunction

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        wcnt_d  = wcnt_q;
        mix     = '0;
        for (int c = 0; c < CH; c++) begin
            s_d[c] = s_q[c];
            z_d[c] = z_q[c];
        end
        if (state_q == ST_IDLE) begin
            if (randomize) begin
                // A zero mix would lock the LFSR, so fall back to the reset fill.
                for (int c = 0; c < CH; c++) begin
                    mix = s_q[c] ^ rotl(e_q, c);
                    if (mix == '0) begin
                        mix = seed_of(c);
                    end
                    s_d[c] = mix;
                    z_d[c] = mix;
                end
                pos_d = '0;
                if (WARMUP > 0) begin
                    state_d = ST_WARMUP;
                    wcnt_d  = 8'(WARMUP);
                end
            end else if (rerun) begin
                for (int c = 0; c < CH; c++) begin
                    s_d[c] = z_q[c];
                end
                pos_d = '0;
            end else if (step) begin
                for (int c = 0; c < CH; c++) begin
                    s_d[c] = lfsr_next(s_q[c]);
                end
                pos_d = POS_W'(pos_q + 1'b1);
            end
        end else begin
            // Seed advances with the state so a later rerun replays post-warm-up.
            for (int c = 0; c < CH; c++) begin
                s_d[c] = lfsr_next(s_q[c]);
                z_d[c] = lfsr_next(z_q[c]);
            end
            wcnt_d = 8'(wcnt_q - 8'd1);
            if (wcnt_q == 8'd1) begin
                state_d = ST_IDLE;
            end
        end
        busy_d = (state_d == ST_WARMUP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            e_q     <= '0;
            pos_q   <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                s_q[c] <= seed_of(c);
                z_q[c] <= seed_of(c);
            end
        end else begin
            state_q <= state_d;
            e_q     <= W'(e_q + 1'b1);
            pos_q   <= pos_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            for (int c = 0; c < CH; c++) begin
                s_q[c] <= s_d[c];
                z_q[c] <= z_d[c];
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_out
        assign random[c] = s_q[c][W-1];
        for (genvar k = 0; k < LA; k++) begin : g_la
            assign randLA[c*LA+k] = s_q[c][W-1-k];
        end
    end

    assign pos  = pos_q;
    assign busy = busy_q;

endmodule
